// File: rtl/scanline_pingpong_buffer.sv
// Double-buffered scanline store: the TIA fills one bank while VGA reads the other,
// with horizontal pixel upscale, vertical line repeat and tear-free bank swaps.
module scanline_pingpong_buffer #(
  parameter int                DATA_W      = 7,
  parameter int                DEPTH       = 160,
  parameter int                XPOS_W      = 8,
  parameter int                HPOS_W      = 10,
  parameter int                SCALE_SHIFT = 2,
  parameter int                H_OFFSET    = 0,
  parameter int                LINE_REPEAT = 2,
  parameter logic [DATA_W-1:0] BORDER      = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [XPOS_W-1:0] wr_xpos,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_line_done,
  input  logic [HPOS_W-1:0] rd_hpos,
  input  logic              rd_line_start,
  input  logic              display_on,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  output logic              rd_bank,
  output logic              overrun,
  output logic              underrun,
  input  logic              flag_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic [3:0]        rep_cnt_q, rep_cnt_d;
  logic [DATA_W-1:0] pix_q;
  logic              pix_valid_q;

  logic              rep_last, data_rdy, swap, ov_evt, un_evt;
  logic              wr_ok, active, rd_sel;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [HPOS_W:0]   hdiff;
  logic [HPOS_W-1:0] idx;

  assign rep_last = (rep_cnt_q == 4'(LINE_REPEAT - 1));
  assign data_rdy = pending_q | wr_line_done;
  assign swap     = rd_line_start & rep_last & data_rdy;
  // A newer completed line landing on an unconsumed one is an overrun, swap or not.
  assign ov_evt   = wr_line_done & pending_q;
  assign un_evt   = rd_line_start & rep_last & ~data_rdy;

  always_comb begin
    wr_bank_d  = wr_bank_q ^ swap;
    rd_bank_d  = rd_bank_q ^ swap;
    rep_cnt_d  = rep_cnt_q;
    if (rd_line_start) rep_cnt_d = rep_last ? 4'd0 : rep_cnt_q + 4'd1;
    pending_d  = swap ? 1'b0 : (wr_line_done | pending_q);
    overrun_d  = ov_evt | (overrun_q & ~flag_clr);
    underrun_d = un_evt | (underrun_q & ~flag_clr);
  end

  // Offset subtraction carries an extra bit so columns left of H_OFFSET go negative.
  assign hdiff   = {1'b0, rd_hpos} - (HPOS_W + 1)'(H_OFFSET);
  assign idx     = hdiff[HPOS_W-1:0] >> SCALE_SHIFT;
  assign active  = display_on & ~hdiff[HPOS_W] & (32'(idx) < 32'(DEPTH));
  assign rd_addr = AW'(idx);
  assign rd_sel  = rd_bank_q ^ swap;

  assign wr_ok   = 32'(wr_xpos) < 32'(DEPTH);
  assign wr_addr = AW'(wr_xpos);

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem_q[wr_bank_q][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      rep_cnt_q   <= 4'd0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      pix_q       <= BORDER;
      pix_valid_q <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rep_cnt_q   <= rep_cnt_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      pix_q       <= active ? mem_q[rd_sel][rd_addr] : BORDER;
      pix_valid_q <= active;
    end
  end

  assign pix_out   = pix_q;
  assign pix_valid = pix_valid_q;
  assign rd_bank   = rd_bank_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_scanline_pingpong_buffer.sv
// Bench for scanline_pingpong_buffer: pixel scoreboard fed by a reference model,
// plus per-scenario flag/bank checks and an H_OFFSET=32 instance for the window edge.
module tb_scanline_pingpong_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_xpos = '0;
  logic [6:0] wr_data = '0;
  logic       wr_line_done = 1'b0;
  logic [9:0] rd_hpos = '0;
  logic       rd_line_start = 1'b0;
  logic       display_on = 1'b0;
  logic       flag_clr = 1'b0;

  logic [6:0] pix_out, off_pix_out;
  logic       pix_valid, rd_bank, overrun, underrun;
  logic       off_pix_valid, off_rd_bank, off_overrun, off_underrun;

  scanline_pingpong_buffer u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_xpos(wr_xpos), .wr_data(wr_data),
    .wr_line_done(wr_line_done), .rd_hpos(rd_hpos), .rd_line_start(rd_line_start),
    .display_on(display_on), .pix_out(pix_out), .pix_valid(pix_valid), .rd_bank(rd_bank),
    .overrun(overrun), .underrun(underrun), .flag_clr(flag_clr)
  );

  scanline_pingpong_buffer #(.H_OFFSET(32)) u_off (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_xpos(wr_xpos), .wr_data(wr_data),
    .wr_line_done(wr_line_done), .rd_hpos(rd_hpos), .rd_line_start(rd_line_start),
    .display_on(display_on), .pix_out(off_pix_out), .pix_valid(off_pix_valid),
    .rd_bank(off_rd_bank), .overrun(off_overrun), .underrun(off_underrun), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [6:0] p;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [6:0] mm[2][160];
  bit         m_wr, m_rd, m_pend;
  int         m_rep;

  function automatic logic [6:0] pat(int id, int x);
    return 7'(x + id * 37);
  endfunction

  // Advance one clock; the model predicts the pixel the DUT registers on this edge.
  task automatic tick();
    exp_t e;
    bit   rl, sw;
    int   idx;
    @(posedge clk);
    rl  = (m_rep == 1);
    sw  = rd_line_start && rl && (m_pend || wr_line_done);
    e.v = 1'b0;
    e.p = 7'd0;
    if (!reset) begin
      idx = int'(rd_hpos) >> 2;
      if (display_on && idx < 160) begin
        e.v = 1'b1;
        e.p = mm[m_rd ^ sw][idx];
      end
    end
    sbq.push_back(e);
    if (reset) begin
      m_wr = 0; m_rd = 1; m_rep = 0; m_pend = 0;
    end else begin
      if (wr_en && wr_xpos < 160) mm[m_wr][wr_xpos] = wr_data;
      if (rd_line_start) m_rep = rl ? 0 : m_rep + 1;
      if (sw) begin
        m_wr = !m_wr; m_rd = !m_rd; m_pend = 0;
      end else if (wr_line_done) m_pend = 1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_cmp++;
      if (pix_out !== e.p || pix_valid !== e.v) begin
        n_err++;
        $display("FAIL pixel @%0t: got valid=%b pix=%h, want valid=%b pix=%h",
                 $time, pix_valid, pix_out, e.v, e.p);
      end
    end
  end

  task automatic write_line(int id);
    for (int x = 0; x < 160; x++) begin
      wr_en = 1'b1; wr_xpos = 8'(x); wr_data = pat(id, x);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse(bit ld, bit ls);
    wr_line_done = ld; rd_line_start = ls;
    tick();
    wr_line_done = 1'b0; rd_line_start = 1'b0;
  endtask

  task automatic sweep(int lo, int hi);
    display_on = 1'b1;
    for (int h = lo; h <= hi; h++) begin
      rd_hpos = 10'(h);
      tick();
    end
    display_on = 1'b0; rd_hpos = '0;
  endtask

  task automatic clear_flags();
    flag_clr = 1'b1; tick(); flag_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_cmp++;
    if (rd_bank !== 1'b1) begin n_err++; $display("FAIL reset_rd_bank: got %b want 1", rd_bank); end
    n_cmp++;
    if (overrun !== 1'b0 || underrun !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got ov=%b un=%b want 0 0", overrun, underrun);
    end
  endtask

  task automatic test_ramp();
    write_line(0);
    pulse(1, 0);
    pulse(0, 1);
    n_cmp++;
    if (rd_bank !== 1'b1) begin n_err++; $display("FAIL ramp_rep0_bank: got %b want 1", rd_bank); end
    pulse(0, 1);
    n_cmp++;
    if (rd_bank !== 1'b0) begin n_err++; $display("FAIL ramp_swap_bank: got %b want 0", rd_bank); end
    sweep(0, 799);
    n_cmp++;
    if (overrun !== 1'b0 || underrun !== 1'b0) begin
      n_err++; $display("FAIL ramp_flags: got ov=%b un=%b want 0 0", overrun, underrun);
    end
  endtask

  task automatic test_alternate();
    for (int k = 1; k <= 4; k++) begin
      write_line(k);
      pulse(1, 0);
      pulse(0, 1);
      pulse(0, 1);
      n_cmp++;
      if (rd_bank !== 1'(k % 2)) begin
        n_err++; $display("FAIL alt_bank k=%0d: got %b want %0d", k, rd_bank, k % 2);
      end
      n_cmp++;
      if (overrun !== 1'b0 || underrun !== 1'b0) begin
        n_err++; $display("FAIL alt_flags k=%0d: got ov=%b un=%b want 0 0", k, overrun, underrun);
      end
      sweep(0, 40);
    end
  endtask

  task automatic test_overrun();
    write_line(10);
    pulse(1, 0);
    n_cmp++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first: got %b want 0", overrun); end
    write_line(11);
    pulse(1, 0);
    n_cmp++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_second: got %b want 1", overrun); end
    pulse(0, 1);
    pulse(0, 1);
    n_cmp++;
    if (rd_bank !== 1'b1) begin n_err++; $display("FAIL ovr_bank: got %b want 1", rd_bank); end
    sweep(0, 639);
    clear_flags();
    n_cmp++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_underrun();
    pulse(0, 1);
    n_cmp++;
    if (underrun !== 1'b0) begin n_err++; $display("FAIL und_early: got %b want 0", underrun); end
    pulse(0, 1);
    n_cmp++;
    if (underrun !== 1'b1 || rd_bank !== 1'b1) begin
      n_err++; $display("FAIL und_set: got un=%b bank=%b want 1 1", underrun, rd_bank);
    end
    sweep(0, 100);
    clear_flags();
    pulse(0, 1);
    flag_clr = 1'b1;
    pulse(0, 1);
    flag_clr = 1'b0;
    n_cmp++;
    if (underrun !== 1'b1) begin n_err++; $display("FAIL und_event_wins: got %b want 1", underrun); end
    clear_flags();
    n_cmp++;
    if (underrun !== 1'b0) begin n_err++; $display("FAIL und_clear: got %b want 0", underrun); end
  endtask

  task automatic test_coincident();
    write_line(20);
    pulse(0, 1);
    display_on = 1'b1; rd_hpos = 10'd8;
    pulse(1, 1);
    display_on = 1'b0; rd_hpos = '0;
    n_cmp++;
    if (rd_bank !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL coin_np: got bank=%b ov=%b want 0 0", rd_bank, overrun);
    end
    pulse(0, 1);
    pulse(0, 1);
    n_cmp++;
    if (underrun !== 1'b1 || rd_bank !== 1'b0) begin
      n_err++; $display("FAIL coin_pend_cleared: got un=%b bank=%b want 1 0", underrun, rd_bank);
    end
    clear_flags();
    write_line(21);
    pulse(1, 0);
    write_line(22);
    pulse(0, 1);
    pulse(1, 1);
    n_cmp++;
    if (rd_bank !== 1'b1 || overrun !== 1'b1) begin
      n_err++; $display("FAIL coin_p: got bank=%b ov=%b want 1 1", rd_bank, overrun);
    end
    sweep(0, 100);
    clear_flags();
  endtask

  task automatic test_xpos_ignore();
    write_line(40);
    wr_en = 1'b1; wr_data = 7'h55;
    wr_xpos = 8'd160; tick();
    wr_xpos = 8'd255; tick();
    wr_en = 1'b0;
    pulse(1, 0);
    pulse(0, 1);
    pulse(0, 1);
    n_cmp++;
    if (rd_bank !== 1'b0) begin n_err++; $display("FAIL xpos_bank: got %b want 0", rd_bank); end
    sweep(0, 639);
  endtask

  task automatic test_offset();
    display_on = 1'b1;
    rd_hpos = 10'd31; tick();
    n_cmp++;
    if (off_pix_valid !== 1'b0 || off_pix_out !== 7'd0) begin
      n_err++; $display("FAIL off_31: got v=%b p=%h want 0 00", off_pix_valid, off_pix_out);
    end
    rd_hpos = 10'd32; tick();
    n_cmp++;
    if (off_pix_valid !== 1'b1 || off_pix_out !== pat(40, 0)) begin
      n_err++; $display("FAIL off_32: got v=%b p=%h want 1 %h", off_pix_valid, off_pix_out, pat(40, 0));
    end
    rd_hpos = 10'd671; tick();
    n_cmp++;
    if (off_pix_valid !== 1'b1 || off_pix_out !== pat(40, 159)) begin
      n_err++; $display("FAIL off_671: got v=%b p=%h want 1 %h", off_pix_valid, off_pix_out, pat(40, 159));
    end
    rd_hpos = 10'd672; tick();
    n_cmp++;
    if (off_pix_valid !== 1'b0 || off_pix_out !== 7'd0) begin
      n_err++; $display("FAIL off_672: got v=%b p=%h want 0 00", off_pix_valid, off_pix_out);
    end
    display_on = 1'b0; rd_hpos = '0;
    n_cmp++;
    if (off_rd_bank !== 1'b0 || off_overrun !== 1'b0 || off_underrun !== 1'b0) begin
      n_err++; $display("FAIL off_state: got bank=%b ov=%b un=%b want 0 0 0",
                        off_rd_bank, off_overrun, off_underrun);
    end
  endtask

  task automatic test_reset_midline();
    pulse(1, 0);
    display_on = 1'b1; rd_hpos = 10'd100;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++;
    if (pix_valid !== 1'b0 || rd_bank !== 1'b1) begin
      n_err++; $display("FAIL rst_mid: got v=%b bank=%b want 0 1", pix_valid, rd_bank);
    end
    display_on = 1'b0; rd_hpos = '0;
    pulse(0, 1);
    n_cmp++;
    if (underrun !== 1'b0 || rd_bank !== 1'b1) begin
      n_err++; $display("FAIL rst_rep0: got un=%b bank=%b want 0 1", underrun, rd_bank);
    end
    pulse(0, 1);
    n_cmp++;
    if (underrun !== 1'b1 || rd_bank !== 1'b1) begin
      n_err++; $display("FAIL rst_pend_drop: got un=%b bank=%b want 1 1", underrun, rd_bank);
    end
    clear_flags();
    write_line(50);
    pulse(1, 0);
    pulse(0, 1);
    pulse(0, 1);
    n_cmp++;
    if (rd_bank !== 1'b0) begin n_err++; $display("FAIL rst_swap: got %b want 0", rd_bank); end
    sweep(0, 200);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_alternate();
    test_overrun();
    test_underrun();
    test_coincident();
    test_xpos_ignore();
    test_offset();
    test_reset_midline();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
